// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary to five-digit BCD converter.
// One conversion per accepted start; results held until the next completes.
module bin_to_bcd_seq #(
  parameter int IN_W = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] bin,
  input  logic            sign_in,
  output logic [3:0]      D0,
  output logic [3:0]      D1,
  output logic [3:0]      D2,
  output logic [3:0]      D3,
  output logic [3:0]      D4,
  output logic            neg,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [4:0] CNT_INIT = 5'(IN_W);

  state_t          state;
  logic [IN_W-1:0] shreg;
  logic [19:0]     scratch;
  logic [4:0]      count;
  logic            sign_q;
  logic [19:0]     adj;
  logic [19:0]     nxt;

  // Add-3 on every nibble >= 5 before the shift, no carry between nibbles.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 5; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    nxt = {adj[18:0], shreg[IN_W-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      count   <= '0;
      sign_q  <= 1'b0;
      D0      <= '0;
      D1      <= '0;
      D2      <= '0;
      D3      <= '0;
      D4      <= '0;
      neg     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shreg   <= bin;
            sign_q  <= sign_in;
            scratch <= '0;
            count   <= CNT_INIT;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= nxt;
          shreg   <= shreg << 1;
          count   <= count - 5'd1;
          if (count == 5'd1) begin
            D0    <= nxt[3:0];
            D1    <= nxt[7:4];
            D2    <= nxt[11:8];
            D3    <= nxt[15:12];
            D4    <= nxt[19:16];
            neg   <= sign_q;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
